// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FPU between two requesters. Round-robin grant,
// level-sensitive start/funct/operand drive for the whole op, valid/ready
// response back to the owner, and a watchdog for a done that never arrives.

`ifndef FUNCT_W
`define FUNCT_W 5
`endif

module fpu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [1:0]                      i_req_valid,
  output logic [1:0]                      o_req_ready,
  input  logic [1:0][`FUNCT_W-1:0]        i_req_funct,
  input  logic [1:0][DATA_W-1:0]          i_req_rs1,
  input  logic [1:0][DATA_W-1:0]          i_req_rs2,
  input  logic [1:0][DATA_W-1:0]          i_req_rs3,
  input  logic [1:0][DATA_W-1:0]          i_req_rs1_i,
  output logic [1:0]                      o_rsp_valid,
  input  logic [1:0]                      i_rsp_ready,
  output logic [DATA_W-1:0]               o_rsp_res,
  output logic                            o_rsp_err,
  output logic                            o_fpu_start,
  output logic [`FUNCT_W-1:0]             o_fpu_funct,
  output logic [DATA_W-1:0]               o_fpu_rs1,
  output logic [DATA_W-1:0]               o_fpu_rs2,
  output logic [DATA_W-1:0]               o_fpu_rs3,
  output logic [DATA_W-1:0]               o_fpu_rs1_i,
  input  logic [DATA_W-1:0]               i_fpu_res,
  input  logic                            i_fpu_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [`FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]   rs1;
    logic [DATA_W-1:0]   rs2;
    logic [DATA_W-1:0]   rs3;
    logic [DATA_W-1:0]   rs1_i;
  } req_t;

  localparam bit             LP_WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  req_t               r_req;
  logic               r_owner;
  logic               r_last_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_res;
  logic               r_err;

  logic               w_grant;
  logic               w_accept;
  logic               w_wd_hit;
  logic               w_rsp_fire;

  // State register; async reset drops fpu_start immediately since it decodes state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, grant selection and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_fire  = 1'b0;
    // Tie goes to whoever did not win last; a lone request always wins.
    w_grant     = (i_req_valid == 2'b11) ? ~r_last_grant : i_req_valid[1];
    w_wd_hit    = LP_WD_EN && (r_cnt == LP_CNT_LAST);
    case (r_state)
      IDLE:  if (|i_req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ISSUE;
             end
      // done is forced low by the FPU in its start cycle, so nothing to look at here.
      ISSUE: w_state_nxt = WAIT;
      WAIT:  if (i_fpu_done || w_wd_hit) w_state_nxt = RESP;
      RESP:  if (i_rsp_ready[r_owner]) begin
               w_rsp_fire  = 1'b1;
               w_state_nxt = IDLE;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; req_ready gated by reset so nothing is offered while held in reset.
  always_comb begin
    o_req_ready = 2'b00;
    if (w_accept && i_rst_n) o_req_ready = w_grant ? 2'b10 : 2'b01;
    o_rsp_valid = 2'b00;
    if (r_state == RESP) o_rsp_valid = r_owner ? 2'b10 : 2'b01;
    o_fpu_start = (r_state == ISSUE) || (r_state == WAIT);
    o_fpu_funct = r_req.funct;
    o_fpu_rs1   = r_req.rs1;
    o_fpu_rs2   = r_req.rs2;
    o_fpu_rs3   = r_req.rs3;
    o_fpu_rs1_i = r_req.rs1_i;
    o_rsp_res   = r_res;
    o_rsp_err   = r_err;
  end

  // Request latch, watchdog counter, result capture and round-robin history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_res        <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.funct <= i_req_funct[w_grant];
        r_req.rs1   <= i_req_rs1[w_grant];
        r_req.rs2   <= i_req_rs2[w_grant];
        r_req.rs3   <= i_req_rs3[w_grant];
        r_req.rs1_i <= i_req_rs1_i[w_grant];
        r_owner     <= w_grant;
      end
      case (r_state)
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (i_fpu_done) begin
            r_res <= i_fpu_res;
            r_err <= 1'b0;
          end else if (w_wd_hit) begin
            // Abandoned op: start drops in RESP and any late result is never forwarded.
            r_res <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (w_rsp_fire) r_last_grant <= r_owner;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural FPU stand-in, per-requester drivers,
// response scoreboard and a negedge monitor.

`ifndef FUNCT_W
`define FUNCT_W 5
`endif

module tb_fpu_arbiter;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int LAT = 3;   // FPU stand-in raises done on the 3rd WAIT cycle
  localparam logic [`FUNCT_W-1:0] OP_ADD = 0;
  localparam logic [`FUNCT_W-1:0] OP_MUL = 2;
  localparam logic [`FUNCT_W-1:0] OP_DIV = 3;

  typedef struct {
    logic          owner;
    logic [DW-1:0] res;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 rv [2];
  logic [`FUNCT_W-1:0]  rf [2];
  logic [DW-1:0]        ra [2];
  logic [DW-1:0]        rb [2];

  logic [1:0]                 req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][`FUNCT_W-1:0]   req_funct;
  logic [1:0][DW-1:0]         req_rs1, req_rs2, req_rs3, req_rs1_i;
  logic [DW-1:0]              rsp_res, fpu_rs1, fpu_rs2, fpu_rs3, fpu_rs1_i, fpu_res;
  logic                       rsp_err, fpu_start, fpu_done;
  logic [`FUNCT_W-1:0]        fpu_funct;

  assign req_valid = {rv[1], rv[0]};
  assign req_funct = {rf[1], rf[0]};
  assign req_rs1   = {ra[1], ra[0]};
  assign req_rs2   = {rb[1], rb[0]};
  assign req_rs3   = {32'h1111_0003, 32'h0000_0A03};
  assign req_rs1_i = {32'h2222_0001, 32'h0000_0B01};

  fpu_arbiter #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_funct(req_funct), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2),
    .i_req_rs3(req_rs3), .i_req_rs1_i(req_rs1_i),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_res(rsp_res), .o_rsp_err(rsp_err),
    .o_fpu_start(fpu_start), .o_fpu_funct(fpu_funct),
    .o_fpu_rs1(fpu_rs1), .o_fpu_rs2(fpu_rs2), .o_fpu_rs3(fpu_rs3), .o_fpu_rs1_i(fpu_rs1_i),
    .i_fpu_res(fpu_res), .i_fpu_done(fpu_done)
  );

  // FPU stand-in: known single-precision results for the ops used here.
  function automatic logic [DW-1:0] fmodel(input logic [`FUNCT_W-1:0] f, input logic [DW-1:0] a, b);
    fmodel = 32'hBAD0_BAD0;
    if (f == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) fmodel = 32'h4040_0000;
    if (f == OP_ADD && a == 32'h4000_0000 && b == 32'h4000_0000) fmodel = 32'h4080_0000;
    if (f == OP_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) fmodel = 32'h40C0_0000;
    if (f == OP_MUL && a == 32'h4080_0000 && b == 32'h3F00_0000) fmodel = 32'h4000_0000;
    if (f == OP_DIV && a == 32'h40C0_0000 && b == 32'h4000_0000) fmodel = 32'h4040_0000;
    if (f == OP_DIV && a == 32'h3F80_0000 && b == 32'h4080_0000) fmodel = 32'h3E80_0000;
  endfunction

  logic [7:0] fcnt;
  logic       stuck;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)               fcnt <= '0;
    else if (!fpu_start)      fcnt <= '0;
    else if (fcnt != 8'hFF)   fcnt <= fcnt + 8'd1;
  assign fpu_done = fpu_start && (fcnt >= 8'(LAT)) && !stuck;
  assign fpu_res  = fmodel(fpu_funct, fpu_rs1, fpu_rs2);

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc [2];
  exp_t sb [$];
  bit   grants [$];
  int   low_run = 0;
  bit   seen_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present one request on requester r until it is granted; queue its expected response.
  task automatic drive(input int r, input logic [`FUNCT_W-1:0] f, input logic [DW-1:0] a, b,
                       input logic [DW-1:0] er, input logic ee);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(posedge clk); #1;
    rf[r] = f; ra[r] = a; rb[r] = b; rv[r] = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    if (!got) chk("req_timeout", 64'd0, 64'd1);
    else begin
      e.owner = r[0]; e.res = er; e.err = ee;
      sb.push_back(e);
      acc_cyc[r] = cyc;
    end
    @(posedge clk); #1;
    rv[r] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rsp(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) got = 1'b1;
    end
    if (!got) chk(tag, 64'd0, 64'd1);
  endtask

  // Response scoreboard, grant order log and start re-arm gap.
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run    <= 0;
      seen_start <= 1'b0;
    end else begin
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          chk("rsp_owner", 64'(rsp_valid), sb[0].owner ? 64'd2 : 64'd1);
          chk("rsp_res", 64'(rsp_res), 64'(sb[0].res));
          chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
          sb.delete(0);
        end
      end
      if (req_ready != 2'b00) begin
        chk("req_onehot", 64'($onehot(req_ready)), 64'd1);
        grants.push_back(req_ready[1]);
      end
      if (fpu_start) begin
        if (low_run != 0 && seen_start) chk("start_gap_ge2", 64'(low_run >= 2), 64'd1);
        low_run    <= 0;
        seen_start <= 1'b1;
      end else begin
        low_run <= low_run + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    rv[0] = 1'b1; rv[1] = 1'b1;   // valid during reset must not produce a ready
    rf[0] = '0; rf[1] = '0; ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    rsp_ready = 2'b11;
    stuck = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_res", 64'(rsp_res), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_fpu_start", 64'(fpu_start), 64'd0);
    chk("rst_fpu_funct", 64'(fpu_funct), 64'd0);
    chk("rst_fpu_rs1", 64'(fpu_rs1), 64'd0);
    rv[0] = 1'b0; rv[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention: first tie after reset goes to 0, then strict alternation
    grants.delete();
    fork
      begin
        drive(0, OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
        drive(0, OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
      end
      begin
        drive(1, OP_MUL, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, 1'b0);
        drive(1, OP_MUL, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, 1'b0);
      end
    join
    wait_drain();
    chk("rr_count", 64'(grants.size()), 64'd4);
    if (grants.size() == 4) begin
      chk("rr_g0", 64'(grants[0]), 64'd0);
      chk("rr_g1", 64'(grants[1]), 64'd1);
      chk("rr_g2", 64'(grants[2]), 64'd0);
      chk("rr_g3", 64'(grants[3]), 64'd1);
    end

    // Single op with cycle-accurate start and response timing
    drive(0, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    for (int i = 0; i < 1 + LAT; i++) begin
      @(negedge clk);
      chk("single_start_hi", 64'(fpu_start), 64'd1);
    end
    chk("single_fpu_rs1", 64'(fpu_rs1), 64'h3F80_0000);
    chk("single_fpu_rs2", 64'(fpu_rs2), 64'h4000_0000);
    chk("single_fpu_rs3", 64'(fpu_rs3), 64'h0000_0A03);
    chk("single_fpu_rs1_i", 64'(fpu_rs1_i), 64'h0000_0B01);
    @(negedge clk);
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_start_lo", 64'(fpu_start), 64'd0);
    chk("single_latency", 64'(cyc - acc_cyc[0]), 64'(2 + LAT));
    wait_drain();

    // Back-to-back identical opcode on requester 1
    drive(1, OP_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    drive(1, OP_DIV, 32'h3F80_0000, 32'h4080_0000, 32'h3E80_0000, 1'b0);
    wait_drain();

    // Response backpressure on requester 0 while requester 1 waits
    @(posedge clk); #1 rsp_ready = 2'b10;
    fork
      drive(0, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
      begin
        repeat (2) @(posedge clk);
        drive(1, OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
      end
      begin
        wait_rsp("bp_rsp_timeout");
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_valid", 64'(rsp_valid), 64'd1);
          chk("bp_res", 64'(rsp_res), 64'h4040_0000);
          chk("bp_stall", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_no_early", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_grant1", 64'(req_ready), 64'd2);
      end
    join
    wait_drain();
    rsp_ready = 2'b11;

    // Watchdog: done stuck low, then normal recovery
    stuck = 1'b1;
    drive(0, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b1);
    wait_rsp("wd_rsp_timeout");
    chk("wd_latency", 64'(cyc - acc_cyc[0]), 64'(TO + 2));
    chk("wd_err_flag", 64'(rsp_err), 64'd1);
    wait_drain();
    stuck = 1'b0;
    drive(1, OP_ADD, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
    wait_drain();

    // Asynchronous reset during WAIT
    drive(0, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_fpu_start", 64'(fpu_start), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_fpu_funct", 64'(fpu_funct), 64'd0);
    chk("arst_fpu_rs1", 64'(fpu_rs1), 64'd0);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    grants.delete();
    fork
      drive(0, OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
      drive(1, OP_MUL, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, 1'b0);
    join
    wait_drain();
    chk("arst_tie_count", 64'(grants.size()), 64'd2);
    if (grants.size() != 0) chk("arst_first_tie", 64'(grants[0]), 64'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
